mult_m_seq: RTL and testbench

Sequential, parametrised successor to the combinational 5x5 matrix multiplier. It computes C = A x B for signed square matrices with one multiply-accumulate per clock. The active dimension is selectable at run time, up to the synthesis maximum N. A start/busy/done handshake lets the coprocessor control FSM launch an operation and poll for its result. Result handling is either saturating or wrap-around, with a sticky overflow flag.

---
 rtl/mult_pkg.sv | 28 ++
 rtl/mac_sat.sv | 54 +++++
 rtl/mult_m_seq.sv | 126 ++++++++++++
 tb/tb_mult_m_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types, default sizes and packing/saturation helpers for the sequential
// matrix multiplier and its testbench.
package mult_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int DEF_N  = 5;
  localparam int DEF_W  = 8;
  localparam int DEF_AW = 2 * DEF_W + $clog2(DEF_N);

  // Bit offset of element (r,c) in a row-major bus; element (0,0) sits at the MSB end.
  function automatic int idx_nw(input int r, input int c, input int nn, input int ww);
    return (nn * nn - 1 - (r * nn + c)) * ww;
  endfunction

  function automatic int idx(input int r, input int c);
    return idx_nw(r, c, DEF_N, DEF_W);
  endfunction

  function automatic longint smax(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

  function automatic longint smin(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/mac_sat.sv
// Signed multiply-accumulate register with clear/load, followed by a
// combinational saturate-or-wrap stage and an out-of-range flag.
module mac_sat
  import mult_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int AW = DEF_AW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sat_en,
  output logic [W-1:0] result,
  output logic         ovf_det
);

  localparam logic signed [AW-1:0] MAX_A = AW'(smax(W));
  localparam logic signed [AW-1:0] MIN_A = AW'(smin(W));

  logic signed [2*W-1:0] prod;
  logic signed [AW-1:0]  prod_ext;
  logic signed [AW-1:0]  acc_reg;
  logic                  above;
  logic                  below;

  assign prod     = $signed(a) * $signed(b);
  assign prod_ext = AW'(prod);

  // load starts a new dot product without a separate clear cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_reg <= '0;
    end else if (clr) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= load ? prod_ext : acc_reg + prod_ext;
    end
  end

  assign above   = acc_reg > MAX_A;
  assign below   = acc_reg < MIN_A;
  assign ovf_det = above | below;

  always_comb begin
    result = acc_reg[W-1:0];
    if (sat_en && above) result = MAX_A[W-1:0];
    if (sat_en && below) result = MIN_A[W-1:0];
  end

endmodule

// File: rtl/mult_m_seq.sv
// Sequential signed matrix multiplier: one MAC per clock over a run-time
// selectable n x n sub-matrix, with start/busy/done handshake and sticky overflow.
module mult_m_seq
  import mult_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int W  = DEF_W,
  parameter int SW = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SW-1:0]    size,
  input  logic             sat_en,
  input  logic [N*N*W-1:0] lin,
  input  logic [N*N*W-1:0] col,
  output logic [N*N*W-1:0] n_out,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  localparam int AW = 2 * W + $clog2(N);

  state_t             state_reg, state_next;
  logic [N*N*W-1:0]   a_reg, b_reg, n_out_reg;
  logic [SW-1:0]      n_reg, i_reg, j_reg, k_reg, wr_i_reg, wr_j_reg, n_clamp;
  logic               sat_reg, wr_pend_reg, ovf_reg, busy_reg, done_reg;
  logic               accept, calc, last_k, last_j, last_i;
  logic [W-1:0]       a_elem, b_elem, res;
  logic               res_ovf;

  assign n_clamp = (size == '0 || size > SW'(N)) ? SW'(N) : size;
  assign accept  = (state_reg == IDLE) && start;
  assign calc    = (state_reg == CALC);
  assign last_k  = (k_reg == n_reg - SW'(1));
  assign last_j  = (j_reg == n_reg - SW'(1));
  assign last_i  = (i_reg == n_reg - SW'(1));

  assign a_elem = a_reg[idx_nw(int'(i_reg), int'(k_reg), N, W) +: W];
  assign b_elem = b_reg[idx_nw(int'(k_reg), int'(j_reg), N, W) +: W];

  mac_sat #(.W(W), .AW(AW)) u_mac (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .en      (calc),
    .load    (k_reg == '0),
    .a       (a_elem),
    .b       (b_elem),
    .sat_en  (sat_reg),
    .result  (res),
    .ovf_det (res_ovf)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (last_k && last_j && last_i) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Element writeback trails its last MAC by one cycle, so the final write
  // lands on the edge that leaves DONE, together with the registered done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_reg       <= '0;
      b_reg       <= '0;
      n_reg       <= '0;
      sat_reg     <= 1'b0;
      i_reg       <= '0;
      j_reg       <= '0;
      k_reg       <= '0;
      wr_i_reg    <= '0;
      wr_j_reg    <= '0;
      wr_pend_reg <= 1'b0;
      n_out_reg   <= '0;
      ovf_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= (state_reg == DONE);
      if (accept) begin
        a_reg       <= lin;
        b_reg       <= col;
        n_reg       <= n_clamp;
        sat_reg     <= sat_en;
        i_reg       <= '0;
        j_reg       <= '0;
        k_reg       <= '0;
        wr_pend_reg <= 1'b0;
        n_out_reg   <= '0;
        ovf_reg     <= 1'b0;
        busy_reg    <= 1'b1;
      end else begin
        wr_pend_reg <= calc && last_k;
        if (calc) begin
          k_reg    <= last_k ? '0 : k_reg + SW'(1);
          wr_i_reg <= i_reg;
          wr_j_reg <= j_reg;
          if (last_k) j_reg <= last_j ? '0 : j_reg + SW'(1);
          if (last_k && last_j) i_reg <= last_i ? '0 : i_reg + SW'(1);
        end
        if (wr_pend_reg) begin
          n_out_reg[idx_nw(int'(wr_i_reg), int'(wr_j_reg), N, W) +: W] <= res;
          ovf_reg <= ovf_reg | res_ovf;
        end
        if (state_reg == DONE) busy_reg <= 1'b0;
      end
    end
  end

  assign n_out = n_out_reg;
  assign busy  = busy_reg;
  assign done  = done_reg;
  assign ovf   = ovf_reg;

endmodule

// File: tb/tb_mult_m_seq.sv
// Self-checking bench for mult_m_seq: directed and random runs against an
// arithmetic reference model, plus reset, isolation and abort scenarios.
module tb_mult_m_seq;
  import mult_pkg::*;

  localparam int N  = DEF_N;
  localparam int W  = DEF_W;
  localparam int SW = $clog2(N + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [SW-1:0]    size;
  logic             sat_en;
  logic [N*N*W-1:0] lin, col, n_out;
  logic             busy, done, ovf;

  int errors = 0;
  int checks = 0;
  int ma [N][N];
  int mb [N][N];

  always #5 clk = ~clk;

  mult_m_seq #(.N(N), .W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .size   (size),
    .sat_en (sat_en),
    .lin    (lin),
    .col    (col),
    .n_out  (n_out),
    .busy   (busy),
    .done   (done),
    .ovf    (ovf)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pack_mats();
    lin = '0;
    col = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        lin[idx(r, c) +: W] = W'(ma[r][c]);
        col[idx(r, c) +: W] = W'(mb[r][c]);
      end
  endtask

  function automatic longint ref_sum(input int r, input int c, input int n);
    longint s = 0;
    for (int k = 0; k < n; k++) s += longint'(ma[r][k]) * longint'(mb[k][c]);
    return s;
  endfunction

  function automatic longint ref_elem(input longint s, input bit sat);
    longint v;
    if (sat) begin
      v = s;
      if (s > smax(W)) v = smax(W);
      if (s < smin(W)) v = smin(W);
    end else begin
      v = s & ((longint'(1) << W) - 1);
      if (v >= (longint'(1) << (W - 1))) v -= (longint'(1) << W);
    end
    return v;
  endfunction

  task automatic check_idle_zero(input string tag);
    check({tag, " n_out"}, 64'(n_out == '0), 64'(1));
    check({tag, " busy"}, 64'(busy), 64'(0));
    check({tag, " done"}, 64'(done), 64'(0));
    check({tag, " ovf"}, 64'(ovf), 64'(0));
  endtask

  // Launch one operation from the current ma/mb, scramble inputs after the
  // start edge, and compare latency, result matrix and ovf with the model.
  task automatic run_op(input int sz, input bit sat, input string tag);
    int     n;
    int     cyc;
    bit     got;
    bit     exp_ovf;
    longint s;
    logic [W-1:0] exp_e;
    n = (sz == 0 || sz > N) ? N : sz;
    pack_mats();
    size   = SW'(sz);
    sat_en = sat;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    sat_en = ~sat;
    size   = SW'($urandom_range(0, (1 << SW) - 1));
    for (int e = 0; e < N * N; e++) begin
      lin[e*W +: W] = W'($urandom);
      col[e*W +: W] = W'($urandom);
    end
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < n * n * n + 20) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) check({tag, " busy"}, 64'(busy), 64'(1));
      if (done) got = 1'b1;
    end
    check({tag, " done seen"}, 64'(got), 64'(1));
    check({tag, " latency"}, 64'(cyc), 64'(n * n * n + 1));
    check({tag, " busy at done"}, 64'(busy), 64'(0));
    exp_ovf = 1'b0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        exp_e = '0;
        if (r < n && c < n) begin
          s = ref_sum(r, c, n);
          if (s > smax(W) || s < smin(W)) exp_ovf = 1'b1;
          exp_e = W'(ref_elem(s, sat));
        end
        check($sformatf("%s C[%0d][%0d]", tag, r, c), 64'(n_out[idx(r, c) +: W]), 64'(exp_e));
      end
    check({tag, " ovf"}, 64'(ovf), 64'(exp_ovf));
    $display("op %s n=%0d sat=%0d latency=%0d ovf=%0b", tag, n, sat, cyc, ovf);
    @(posedge clk);
    #1;
    check({tag, " done pulse ends"}, 64'(done), 64'(0));
  endtask

  task automatic fill_small();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma[r][c] = 0;
        mb[r][c] = 0;
      end
    ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
    mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
  endtask

  task automatic fill_const(input int va, input int vb);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma[r][c] = va;
        mb[r][c] = vb;
      end
  endtask

  initial begin
    rst    = 1'b0;
    start  = 1'b1;
    size   = '0;
    sat_en = 1'b0;
    lin    = '0;
    col    = '0;
    // reset held with start high: reset must win
    repeat (3) @(posedge clk);
    #1;
    check_idle_zero("in reset");
    @(negedge clk) begin
      start = 1'b0;
      rst   = 1'b1;
    end
    for (int t = 0; t < 3; t++) begin
      @(posedge clk);
      #1;
      check_idle_zero($sformatf("idle %0d", t));
    end

    fill_small();
    run_op(2, 1'b1, "2x2");

    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma[r][c] = (r == c) ? 1 : 0;
        mb[r][c] = r * N + c + 1;
      end
    run_op(5, 1'b0, "identity");

    fill_const(127, 127);
    run_op(5, 1'b1, "max sat");
    run_op(5, 1'b0, "max wrap");
    fill_const(-128, 127);
    run_op(0, 1'b1, "neg sat size0");
    fill_const(-128, -128);
    run_op(7, 1'b1, "minmin size7");

    for (int t = 0; t < 4; t++) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          ma[r][c] = int'($urandom_range(0, 255)) - 128;
          mb[r][c] = int'($urandom_range(0, 255)) - 128;
        end
      run_op(int'($urandom_range(0, (1 << SW) - 1)), 1'($urandom_range(0, 1)),
             $sformatf("random %0d", t));
    end

    // abort: ignored restart at cycle 10, reset at cycle 40
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma[r][c] = (r == c) ? 1 : 0;
        mb[r][c] = r * N + c + 1;
      end
    pack_mats();
    size   = SW'(5);
    sat_en = 1'b1;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    check("abort busy before reset", 64'(busy), 64'(1));
    check("abort partial written", 64'(n_out != '0), 64'(1));
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_idle_zero("abort");
    @(negedge clk) rst = 1'b1;
    fill_small();
    run_op(2, 1'b1, "after abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
